// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage, one req/ack data-bus transaction per load/store.
// Aligns and extends load data, then drives a one-cycle register write-back.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ex2mem_*             request from execute (mem_en, wb_en, addr, opcode,
//                        funct3, rd, store_data)
//   mem2cu_stall_o       hold upstream stages while an access is in flight
//   mem2cu_bus_err_o     one-cycle pulse when an access times out
//   mem2cu_misalign_o    one-cycle pulse when a misaligned access is rejected
//   bus_*                data bus (req/we/addr/be/wdata out, ack/rdata in)
//   mem2regs_*           register-file write-back (wb_en, rd_addr, rd_data)
//
// Optional feature: define MEMU_MISALIGN_CHECK_EN to reject misaligned
// halfword/word accesses instead of silently aligning them down.
module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex2mem_mem_en_i,
  input  logic              ex2mem_wb_en_i,
  input  logic [ADDR_W-1:0] ex2mem_mem_addr_i,
  input  logic [6:0]        ex2mem_opcode_i,
  input  logic [2:0]        ex2mem_funct3_i,
  input  logic [4:0]        ex2mem_rd_i,
  input  logic [DATA_W-1:0] ex2mem_store_data_i,
  output logic              mem2cu_stall_o,
  output logic              mem2cu_bus_err_o,
  output logic              mem2cu_misalign_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              mem2regs_wb_en_o,
  output logic [4:0]        mem2regs_rd_addr_o,
  output logic [DATA_W-1:0] mem2regs_rd_data_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [7:0]        cnt_q;
  logic              ld_q;
  logic              wb_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [4:0]        rd_q;

  logic              is_ld, is_st;
  logic              f3_ld_ok, f3_st_ok;
  logic              req_ok;
  logic              mis_hit;
  logic              accept;
  logic              timeout;
  logic [1:0]        req_off;
  logic [3:0]        be_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ld_data;

  // Request decode
  always_comb begin
    is_ld    = (ex2mem_opcode_i == OP_LOAD);
    is_st    = (ex2mem_opcode_i == OP_STORE);
    f3_ld_ok = ex2mem_funct3_i inside
               {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    f3_st_ok = ex2mem_funct3_i inside
               {3'b000, 3'b001, 3'b010};
    req_ok   = ex2mem_mem_en_i &
               ((is_ld & f3_ld_ok) | (is_st & f3_st_ok));
  end

  // Lane offset: halfwords and words drop the low address bits
  always_comb begin
    req_off = 2'b00;
    unique case (1'b1)
      ex2mem_funct3_i[1:0] == 2'b00:
        req_off = ex2mem_mem_addr_i[1:0];
      ex2mem_funct3_i[1:0] == 2'b01:
        req_off = {ex2mem_mem_addr_i[1], 1'b0};
      default:
        req_off = 2'b00;
    endcase
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = ex2mem_store_data_i;
    if (is_st) begin
      unique case (1'b1)
        ex2mem_funct3_i[1:0] == 2'b00: begin
          be_d    = 4'b0001 << req_off;
          wdata_d = {4{ex2mem_store_data_i[7:0]}};
        end
        ex2mem_funct3_i[1:0] == 2'b01: begin
          be_d    = 4'b0011 << req_off;
          wdata_d = {2{ex2mem_store_data_i[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = ex2mem_store_data_i;
        end
      endcase
    end
  end

`ifdef MEMU_MISALIGN_CHECK_EN
  logic misal;
  always_comb begin
    misal = ((ex2mem_funct3_i[1:0] == 2'b01) & ex2mem_mem_addr_i[0]) |
            ((ex2mem_funct3_i[1:0] == 2'b10) &
             (ex2mem_mem_addr_i[1:0] != 2'b00));
  end
  assign mis_hit = (state_q == S_IDLE) & req_ok & misal;
`else
  assign mis_hit = 1'b0;
`endif

  assign accept  = (state_q == S_IDLE) & req_ok & ~mis_hit;
  assign timeout = (state_q == S_BUS) & ~bus_ack_i &
                   (cnt_q == TO_LAST);

  // Load alignment and extension
  always_comb begin
    shifted = bus_rdata_i >> {off_q, 3'b000};
    ld_data = shifted;
    unique case (f3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_BUS;
      end
      S_BUS: begin
        if (bus_ack_i) state_d = ld_q ? S_WB : S_IDLE;
        else if (timeout) state_d = S_IDLE;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    bus_req_o        = (state_q == S_BUS);
    mem2regs_wb_en_o = (state_q == S_WB) & wb_q & (rd_q != 5'd0);
    mem2cu_stall_o   = (state_q != S_IDLE) |
                       ((state_q == S_IDLE) & req_ok);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q              <= 8'd0;
      ld_q               <= 1'b0;
      wb_q               <= 1'b0;
      f3_q               <= 3'd0;
      off_q              <= 2'd0;
      rd_q               <= 5'd0;
      bus_we_o           <= 1'b0;
      bus_addr_o         <= '0;
      bus_be_o           <= 4'd0;
      bus_wdata_o        <= '0;
      mem2cu_bus_err_o   <= 1'b0;
      mem2cu_misalign_o  <= 1'b0;
      mem2regs_rd_addr_o <= 5'd0;
      mem2regs_rd_data_o <= '0;
    end else begin
      cnt_q             <= (state_q == S_BUS) ? cnt_q + 8'd1 : 8'd0;
      mem2cu_bus_err_o  <= timeout;
      mem2cu_misalign_o <= mis_hit;
      if (accept) begin
        ld_q        <= is_ld;
        wb_q        <= ex2mem_wb_en_i;
        f3_q        <= ex2mem_funct3_i;
        off_q       <= req_off;
        rd_q        <= ex2mem_rd_i;
        bus_we_o    <= is_st;
        bus_addr_o  <= {ex2mem_mem_addr_i[ADDR_W-1:2], 2'b00};
        bus_be_o    <= be_d;
        bus_wdata_o <= wdata_d;
      end
      if ((state_q == S_BUS) && bus_ack_i && ld_q) begin
        mem2regs_rd_addr_o <= rd_q;
        mem2regs_rd_data_o <= ld_data;
      end
    end
  end

endmodule
